// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// Instruction queue between fetch (PC register + instruction memory) and
// decode. Each entry holds one {pc, instr} pair. Valid/ready handshakes on
// both sides let fetch run ahead while decode is stalled. A flush (taken
// jump/branch) discards every queued entry so decode never sees wrong-path
// instructions.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   reset      synchronous active-low reset (0 = reset)
//   flush      discard all entries; the same-cycle push/pop is dropped
//   in_valid   fetch presents in_pc/in_instr
//   in_ready   buffer can accept an entry this cycle (count != DEPTH)
//   in_pc      pc of the fetched instruction
//   in_instr   fetched instruction word
//   out_valid  head entry is valid (count != 0)
//   out_ready  decode consumes the head entry this cycle
//   out_pc     pc of the head entry, 0 when empty
//   out_instr  instr of the head entry, 0 when empty
//   count      number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Entry storage. The head must be visible in the cycle right after the
  // push edge, so the read is asynchronous from the registered rd_ptr.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg,  count_next;

  logic             push;
  logic             pop;
  logic [DEPTH-1:0] entry_we;

  // Handshakes depend only on registered occupancy: no full-bypass and no
  // empty-bypass paths exist.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign count     = count_reg;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : '0;

  // Per-entry write enables; a flush suppresses the write so the wrong-path
  // instruction never lands in the array.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push & ~flush & (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        pc_mem[i]    <= in_pc;
        instr_mem[i] <= in_instr;
      end
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_buffer
//
// Directed plus random stimulus for fetch_buffer. The reference is a plain
// queue of {pc, instr} pairs: push appends, pop removes the head, flush and
// reset empty it. All DUT outputs are compared against that queue one time
// unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [AW:0]     count;

  int errors = 0;
  int checks = 0;

  logic [2*XLEN-1:0] model_q[$];

  fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_all(input string tag);
    logic [XLEN-1:0] exp_pc;
    logic [XLEN-1:0] exp_instr;
    exp_pc    = '0;
    exp_instr = '0;
    if (model_q.size() > 0) begin
      exp_pc    = model_q[0][2*XLEN-1:XLEN];
      exp_instr = model_q[0][XLEN-1:0];
    end
    check({tag, ".count"},     64'(count),     64'(model_q.size()));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(model_q.size() != DEPTH));
    check({tag, ".out_pc"},    64'(out_pc),    64'(exp_pc));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(exp_instr));
  endtask

  // One clock cycle: drive inputs, advance the reference, check outputs.
  task automatic step(input string tag, input logic rst_n, input logic fl,
                      input logic iv, input logic [XLEN-1:0] ipc,
                      input logic [XLEN-1:0] iinstr, input logic ordy);
    bit do_push;
    bit do_pop;
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_pc     = ipc;
    in_instr  = iinstr;
    out_ready = ordy;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (!rst_n || fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({ipc, iinstr});
    end
    #1;
    $display("step %-10s rst=%0b fl=%0b iv=%0b pc=%08h ordy=%0b -> cnt=%0d ov=%0b opc=%08h oins=%08h",
             tag, rst_n, fl, iv, ipc, ordy, count, out_valid, out_pc, out_instr);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;

    // Reset and fill
    step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("reset.count_const", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, 1'b0, 1'b1, 32'(4 * i), 32'(8'h11 * (i + 1)), 1'b0);
    check("full.count_const", 64'(count), 64'd4);
    check("full.head_instr", 64'(out_instr), 64'h11);
    step("fifth", 1'b1, 1'b0, 1'b1, 32'h10, 32'h55, 1'b0);

    // Drain order
    for (int i = 0; i < 4; i++) begin
      check("drain.head_pc", 64'(out_pc), 64'(4 * i));
      step("drain", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end
    check("drain.empty_instr", 64'(out_instr), 64'd0);

    // Concurrent push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b1);
      check("stream.count1", 64'(count), 64'd1);
      check("stream.lag_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
    end
    step("drain1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Flush mid-stream
    for (int i = 0; i < 3; i++)
      step("pre_fl", 1'b1, 1'b0, 1'b1, 32'h180 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
    step("flush", 1'b1, 1'b1, 1'b1, 32'h200, 32'hC0, 1'b1);
    check("flush.count_const", 64'(count), 64'd0);
    step("flush2", 1'b1, 1'b1, 1'b1, 32'h204, 32'hC1, 1'b0);
    step("post_fl", 1'b1, 1'b0, 1'b1, 32'h300, 32'hD0, 1'b0);
    check("post_fl.head_pc", 64'(out_pc), 64'h300);
    step("clr", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Full boundary with pop
    for (int i = 0; i < 4; i++)
      step("fill2", 1'b1, 1'b0, 1'b1, 32'h20 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0);
    step("full_pop", 1'b1, 1'b0, 1'b1, 32'h40, 32'hEF, 1'b1);
    check("full_pop.count3", 64'(count), 64'd3);
    step("refill", 1'b1, 1'b0, 1'b1, 32'h40, 32'hEF, 1'b0);
    check("refill.count4", 64'(count), 64'd4);

    // Reset priority over flush/push/pop
    step("clr2", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    step("two_a", 1'b1, 1'b0, 1'b1, 32'h500, 32'h1, 1'b0);
    step("two_b", 1'b1, 1'b0, 1'b1, 32'h504, 32'h2, 1'b0);
    step("rst_pri", 1'b0, 1'b1, 1'b1, 32'h508, 32'h3, 1'b1);
    check("rst_pri.ready", 64'(in_ready), 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic r_n, fl;
      r_n = ($urandom_range(63) != 0);
      fl  = ($urandom_range(15) == 0);
      step("rand", r_n, fl, 1'($urandom_range(1)), $urandom, $urandom,
           1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
